// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard / forwarding controller.
//   - Forwarding-mux select encodings used on fwd_a / fwd_b.
//   - Packed structs for the EX, MEM and WB metadata slots.
//   - src_match(): the single register-dependency test used everywhere.
// Register addresses are stored at REG_ADDR_MAX bits; narrower datapath
// addresses are zero-extended on entry, so RA_W must not exceed REG_ADDR_MAX.
package pipe_hazard_ctrl_pkg;

    localparam int REG_ADDR_MAX = 8;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b10;
    localparam logic [1:0] FWD_MEMWB = 2'b01;

    typedef logic [REG_ADDR_MAX-1:0] reg_addr_t;

    typedef struct packed {
        logic      v;
        reg_addr_t rs;
        reg_addr_t rt;
        logic      use_rs;
        logic      use_rt;
        reg_addr_t rd;
        logic      rw;
        logic      mr;
    } ex_slot_t;

    typedef struct packed {
        logic      v;
        reg_addr_t rd;
        logic      rw;
        logic      mr;
    } mem_slot_t;

    typedef struct packed {
        logic      v;
        reg_addr_t rd;
        logic      rw;
    } wb_slot_t;

    // A source depends on a slot when the slot holds a live register write to
    // the same address and the source is actually read. Register 0 never
    // depends on anything when it is hardwired to zero.
    function automatic logic src_match(
        input logic      slot_v,
        input logic      slot_rw,
        input reg_addr_t slot_rd,
        input reg_addr_t src,
        input logic      use_src,
        input logic      zero_reg
    );
        return slot_v & slot_rw & (slot_rd == src) & use_src
               & ~(zero_reg & (src == '0));
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// sat_counter: W-bit event counter that increments on inc and sticks at
// all-ones instead of wrapping.
//   clk   in  clock, rising edge
//   rst_n in  asynchronous active-low reset (clears count)
//   inc   in  count this cycle
//   count out current value
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (inc && (count_reg != '1)) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: hazard and forwarding controller for a 5-stage pipeline.
// Tracks register-use metadata for the instructions in EX, MEM and WB and
// derives, combinationally from those slots plus the ID-stage inputs:
//   pc_we / ifid_we            - freeze fetch on load-use or external stall
//   ifid/idex/exmem_flush      - bubble insertion (load-use, taken branch)
//   fwd_a / fwd_b              - EX operand forwarding selects
//   id_wt_a / id_wt_b          - ID regfile read takes the WB write data
//   stall_cnt / flush_cnt      - saturating counts of load-use / flush cycles
// Inputs: ext_stall freezes everything; id_* describe the instruction in ID;
// mem_branch_taken reports a taken branch resolved in MEM.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int RA_W     = 5,
    parameter int ZERO_REG = 1,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ext_stall,
    input  logic             id_valid,
    input  logic [RA_W-1:0]  id_rs,
    input  logic [RA_W-1:0]  id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic [RA_W-1:0]  id_rd,
    input  logic             id_regwrite,
    input  logic             id_memread,
    input  logic             mem_branch_taken,
    output logic             pc_we,
    output logic             ifid_we,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             id_wt_a,
    output logic             id_wt_b,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic ZR = (ZERO_REG != 0);

    ex_slot_t  ex_reg;
    mem_slot_t mem_reg;
    wb_slot_t  wb_reg;

    // Per-operand views: index 0 is rs / operand A, index 1 is rt / operand B.
    reg_addr_t  id_src [2];
    logic       id_use [2];
    reg_addr_t  ex_src [2];
    logic       ex_use [2];
    logic [1:0] fwd_sel [2];
    logic [1:0] id_wt;
    logic [1:0] luse_src;

    logic luse_raw;
    logic luse;
    logic branch_flush;

    assign id_src[0] = reg_addr_t'(id_rs);
    assign id_src[1] = reg_addr_t'(id_rt);
    assign id_use[0] = id_use_rs;
    assign id_use[1] = id_use_rt;
    assign ex_src[0] = ex_reg.rs;
    assign ex_src[1] = ex_reg.rt;
    assign ex_use[0] = ex_reg.use_rs;
    assign ex_use[1] = ex_reg.use_rt;

    for (genvar gi = 0; gi < 2; gi++) begin : g_src
        // MEM is the younger producer, so it wins over WB.
        assign fwd_sel[gi] =
            src_match(mem_reg.v, mem_reg.rw, mem_reg.rd, ex_src[gi], ex_use[gi], ZR) ? FWD_EXMEM :
            src_match(wb_reg.v,  wb_reg.rw,  wb_reg.rd,  ex_src[gi], ex_use[gi], ZR) ? FWD_MEMWB :
                                                                                      FWD_RF;
        assign id_wt[gi] = id_valid &
            src_match(wb_reg.v, wb_reg.rw, wb_reg.rd, id_src[gi], id_use[gi], ZR);
        assign luse_src[gi] =
            src_match(ex_reg.v, ex_reg.rw, ex_reg.rd, id_src[gi], id_use[gi], ZR);
    end

    assign fwd_a   = fwd_sel[0];
    assign fwd_b   = fwd_sel[1];
    assign id_wt_a = id_wt[0];
    assign id_wt_b = id_wt[1];

    // luse_raw feeds the EX valid bit; the branch term there already kills
    // the instruction, so suppressing luse on a flush changes nothing there.
    assign luse_raw     = id_valid & ex_reg.v & ex_reg.mr & (|luse_src);
    assign branch_flush = mem_branch_taken & ~ext_stall;
    assign luse         = luse_raw & ~mem_branch_taken & ~ext_stall;

    always_comb begin
        pc_we       = 1'b1;
        ifid_we     = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        if (ext_stall) begin
            pc_we   = 1'b0;
            ifid_we = 1'b0;
        end else if (branch_flush) begin
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
        end else if (luse) begin
            pc_we      = 1'b0;
            ifid_we    = 1'b0;
            idex_flush = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_reg  <= '0;
            mem_reg <= '0;
            wb_reg  <= '0;
        end else if (!ext_stall) begin
            wb_reg.v   <= mem_reg.v;
            wb_reg.rd  <= mem_reg.rd;
            wb_reg.rw  <= mem_reg.rw;
            mem_reg.v  <= ex_reg.v & ~mem_branch_taken;
            mem_reg.rd <= ex_reg.rd;
            mem_reg.rw <= ex_reg.rw;
            mem_reg.mr <= ex_reg.mr;
            ex_reg.v      <= id_valid & ~luse_raw & ~mem_branch_taken;
            ex_reg.rs     <= id_src[0];
            ex_reg.rt     <= id_src[1];
            ex_reg.use_rs <= id_use_rs;
            ex_reg.use_rt <= id_use_rt;
            ex_reg.rd     <= reg_addr_t'(id_rd);
            ex_reg.rw     <= id_regwrite;
            ex_reg.mr     <= id_memread;
        end
    end

    // The load flag in MEM is carried for the datapath's benefit only; no
    // hazard decision here reads it.
    logic unused_mem_mr;
    assign unused_mem_mr = mem_reg.mr;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (luse),
        .count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (branch_flush),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl. Each cycle the ID inputs are driven just after
// the rising edge and the hand-derived expected outputs for that cycle are
// pushed to a queue; on the falling edge the expectation is popped and every
// output is compared against it.
module tb_pipe_hazard_ctrl;

    localparam int RA_W  = 5;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             ext_stall;
    logic             id_valid;
    logic [RA_W-1:0]  id_rs, id_rt, id_rd;
    logic             id_use_rs, id_use_rt, id_regwrite, id_memread;
    logic             mem_branch_taken;
    logic             pc_we, ifid_we, ifid_flush, idex_flush, exmem_flush;
    logic [1:0]       fwd_a, fwd_b;
    logic             id_wt_a, id_wt_b;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.RA_W(RA_W), .ZERO_REG(1), .CNT_W(CNT_W)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .ext_stall        (ext_stall),
        .id_valid         (id_valid),
        .id_rs            (id_rs),
        .id_rt            (id_rt),
        .id_use_rs        (id_use_rs),
        .id_use_rt        (id_use_rt),
        .id_rd            (id_rd),
        .id_regwrite      (id_regwrite),
        .id_memread       (id_memread),
        .mem_branch_taken (mem_branch_taken),
        .pc_we            (pc_we),
        .ifid_we          (ifid_we),
        .ifid_flush       (ifid_flush),
        .idex_flush       (idex_flush),
        .exmem_flush      (exmem_flush),
        .fwd_a            (fwd_a),
        .fwd_b            (fwd_b),
        .id_wt_a          (id_wt_a),
        .id_wt_b          (id_wt_b),
        .stall_cnt        (stall_cnt),
        .flush_cnt        (flush_cnt)
    );

    typedef struct {
        logic       pc_we;
        logic       ifid_we;
        logic [2:0] flush;   // {ifid, idex, exmem}
        logic [1:0] fwd_a;
        logic [1:0] fwd_b;
        logic [1:0] wt;      // {a, b}
        int         sc;
        int         fc;
    } exp_t;

    exp_t exp_q[$];
    int   num_checks = 0;
    int   num_errors = 0;
    int   step       = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        num_checks++;
        if (got !== want) begin
            num_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic push_exp(input logic pw, input logic iw, input logic [2:0] fl,
                            input logic [1:0] fa, input logic [1:0] fb,
                            input logic [1:0] wt, input int sc, input int fc);
        exp_t e;
        e.pc_we = pw; e.ifid_we = iw; e.flush = fl;
        e.fwd_a = fa; e.fwd_b = fb; e.wt = wt; e.sc = sc; e.fc = fc;
        exp_q.push_back(e);
    endtask

    // Shorthand for a cycle with no stall or flush.
    task automatic push_norm(input logic [1:0] fa, input logic [1:0] fb,
                             input logic [1:0] wt, input int sc, input int fc);
        push_exp(1'b1, 1'b1, 3'b000, fa, fb, wt, sc, fc);
    endtask

    task automatic set_id(input logic v, input int rd, input int rs, input int rt,
                          input logic urs, input logic urt, input logic rw, input logic mr);
        id_valid    = v;
        id_rd       = RA_W'(rd);
        id_rs       = RA_W'(rs);
        id_rt       = RA_W'(rt);
        id_use_rs   = urs;
        id_use_rt   = urt;
        id_regwrite = rw;
        id_memread  = mr;
    endtask

    task automatic set_nop();
        set_id(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Compare this cycle's outputs on the falling edge, release any reset,
    // then advance to just after the next rising edge.
    task automatic cyc();
        exp_t e;
        @(negedge clk);
        if (exp_q.size() == 0) begin
            check($sformatf("t%0d queue_empty", step), 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check($sformatf("t%0d pc_we", step),     32'(pc_we),     32'(e.pc_we));
            check($sformatf("t%0d ifid_we", step),   32'(ifid_we),   32'(e.ifid_we));
            check($sformatf("t%0d flushes", step),
                  32'({ifid_flush, idex_flush, exmem_flush}), 32'(e.flush));
            check($sformatf("t%0d fwd_a", step),     32'(fwd_a),     32'(e.fwd_a));
            check($sformatf("t%0d fwd_b", step),     32'(fwd_b),     32'(e.fwd_b));
            check($sformatf("t%0d id_wt", step),     32'({id_wt_a, id_wt_b}), 32'(e.wt));
            check($sformatf("t%0d stall_cnt", step), 32'(stall_cnt), 32'(e.sc));
            check($sformatf("t%0d flush_cnt", step), 32'(flush_cnt), 32'(e.fc));
            $display("t%0d: pc_we=%0b ifid_we=%0b fl=%03b fwd_a=%02b fwd_b=%02b wt=%02b sc=%0d fc=%0d",
                     step, pc_we, ifid_we, {ifid_flush, idex_flush, exmem_flush},
                     fwd_a, fwd_b, {id_wt_a, id_wt_b}, stall_cnt, flush_cnt);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        step++;
    endtask

    initial begin
        rst_n            = 1'b0;
        ext_stall        = 1'b0;
        mem_branch_taken = 1'b0;
        set_nop();

        // Reset state
        push_norm(2'b00, 2'b00, 2'b00, 0, 0); cyc();

        // EX/MEM forwarding: add r3,r1,r2 ; sub r4,r3,r5
        set_id(1, 3, 1, 2, 1, 1, 1, 0); push_norm(2'b00, 2'b00, 2'b00, 0, 0); cyc();
        set_id(1, 4, 3, 5, 1, 1, 1, 0); push_norm(2'b00, 2'b00, 2'b00, 0, 0); cyc();
        set_nop();                      push_norm(2'b10, 2'b00, 2'b00, 0, 0); cyc();

        // MEM/WB forwarding: add r3 ; or r7,r8,r9 ; and r6,r3,r3 ; xor r10,r3,r11 (write-through)
        set_id(1, 3, 1, 2, 1, 1, 1, 0);   push_norm(2'b00, 2'b00, 2'b00, 0, 0); cyc();
        set_id(1, 7, 8, 9, 1, 1, 1, 0);   push_norm(2'b00, 2'b00, 2'b00, 0, 0); cyc();
        set_id(1, 6, 3, 3, 1, 1, 1, 0);   push_norm(2'b00, 2'b00, 2'b00, 0, 0); cyc();
        set_id(1, 10, 3, 11, 1, 1, 1, 0); push_norm(2'b01, 2'b01, 2'b10, 0, 0); cyc();

        // MEM priority: two writers of r3 then and r6,r3,r12
        set_id(1, 3, 1, 2, 1, 1, 1, 0);   push_norm(2'b00, 2'b00, 2'b00, 0, 0); cyc();
        set_id(1, 3, 1, 2, 1, 1, 1, 0);   push_norm(2'b00, 2'b00, 2'b00, 0, 0); cyc();
        set_id(1, 6, 3, 12, 1, 1, 1, 0);  push_norm(2'b00, 2'b00, 2'b00, 0, 0); cyc();
        set_nop();                        push_norm(2'b10, 2'b00, 2'b00, 0, 0); cyc();

        // Load-use: lw r2,(r1) ; add r4,r2,r1 -> one bubble
        set_id(1, 2, 1, 0, 1, 0, 1, 1);   push_norm(2'b00, 2'b00, 2'b00, 0, 0); cyc();
        set_id(1, 4, 2, 1, 1, 1, 1, 0);   push_exp(1'b0, 1'b0, 3'b010, 2'b00, 2'b00, 2'b00, 0, 0); cyc();
        // bubble in EX still carries add's source fields; lw now in MEM
        push_norm(2'b10, 2'b00, 2'b00, 1, 0); cyc();
        set_nop();                        push_norm(2'b01, 2'b00, 2'b00, 1, 0); cyc();

        // Branch flush overriding a load-use: lw r5 ; add r6,r5,r5 with branch taken
        set_id(1, 5, 1, 0, 1, 0, 1, 1);   push_norm(2'b00, 2'b00, 2'b00, 1, 0); cyc();
        set_id(1, 6, 5, 5, 1, 1, 1, 0);
        mem_branch_taken = 1'b1;          push_exp(1'b1, 1'b1, 3'b111, 2'b00, 2'b00, 2'b00, 1, 0); cyc();
        mem_branch_taken = 1'b0;
        set_nop();                        push_norm(2'b00, 2'b00, 2'b00, 1, 1); cyc();
        // killed lw now in WB must not write through to r5
        set_id(1, 7, 5, 1, 1, 1, 1, 0);   push_norm(2'b00, 2'b00, 2'b00, 1, 1); cyc();

        // Register 0: writers and a load of r0, then readers of r0
        set_id(1, 0, 1, 2, 1, 1, 1, 0);   push_norm(2'b00, 2'b00, 2'b00, 1, 1); cyc();
        set_id(1, 0, 1, 0, 1, 0, 1, 1);   push_norm(2'b00, 2'b00, 2'b00, 1, 1); cyc();
        set_id(1, 8, 0, 0, 1, 1, 1, 0);   push_norm(2'b00, 2'b00, 2'b00, 1, 1); cyc();
        set_id(1, 9, 0, 0, 1, 1, 1, 0);   push_norm(2'b00, 2'b00, 2'b00, 1, 1); cyc();

        // External stall for 3 cycles with a branch pending: everything frozen
        set_id(1, 10, 8, 1, 1, 1, 1, 0);  push_norm(2'b00, 2'b00, 2'b00, 1, 1); cyc();
        set_id(1, 11, 10, 8, 1, 1, 1, 0);
        ext_stall        = 1'b1;
        mem_branch_taken = 1'b1;
        for (int i = 0; i < 3; i++) begin
            push_exp(1'b0, 1'b0, 3'b000, 2'b01, 2'b00, 2'b01, 1, 1); cyc();
        end
        ext_stall        = 1'b0;
        mem_branch_taken = 1'b0;
        push_norm(2'b01, 2'b00, 2'b01, 1, 1); cyc();

        // Reset mid-stream with a load in EX and a dependent instruction in ID
        set_id(1, 12, 1, 0, 1, 0, 1, 1);  push_norm(2'b10, 2'b00, 2'b00, 1, 1); cyc();
        set_id(1, 13, 12, 12, 1, 1, 1, 0);
        rst_n = 1'b0;                     push_norm(2'b00, 2'b00, 2'b00, 0, 0); cyc();
        push_norm(2'b00, 2'b00, 2'b00, 0, 0); cyc();

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
        $finish;
    end

    // Backstop so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish, got step %0d expected completion", step);
        $fatal(1, "timeout");
    end

endmodule
